// File: rtl/fp_shift_arbiter.sv
// Shares one 24-bit mantissa right shifter between an FP adder (port 0) and a
// float-to-int converter (port 1); one operation in flight, result held until taken.

module right_shifter (
  input  logic [23:0] din,
  input  logic [4:0]  amt,
  output logic [23:0] dout
);
  assign dout = din >> amt;
endmodule

module fp_shift_arbiter #(
  parameter int AMT_W      = 8,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_vld,
  input  logic [23:0]      req0_mant,
  input  logic [AMT_W-1:0] req0_amt,
  output logic             req0_rdy,
  input  logic             req1_vld,
  input  logic [23:0]      req1_mant,
  input  logic [AMT_W-1:0] req1_amt,
  output logic             req1_rdy,
  output logic             rsp_vld,
  output logic             rsp_id,
  output logic [23:0]      rsp_mant,
  output logic             rsp_sticky,
  input  logic             rsp_rdy,
  output logic             busy
);
  // Handshakes: a request transfers on a rising edge where reqN_vld & reqN_rdy;
  // a response transfers on a rising edge where rsp_vld & rsp_rdy. Valid holds
  // its payload stable until the transfer edge.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             last_gnt;
  logic             gnt_id;
  logic             accept;
  logic             idle;
  logic [23:0]      gnt_mant;
  logic [AMT_W-1:0] gnt_amt;
  logic [23:0]      op_mant;
  logic [4:0]       op_amt;
  logic             op_id;
  logic [23:0]      shift_out;
  logic [23:0]      sticky_mask;

  // Anything at or beyond the mantissa width saturates to 31, which shifts out every bit.
  function automatic logic [4:0] clamp_amt(input logic [AMT_W-1:0] a);
    if (a >= AMT_W'(24)) return 5'd31;
    return a[4:0];
  endfunction

  always_comb begin
    gnt_id = req1_vld;
    if (req0_vld && req1_vld) gnt_id = FIXED_PRIO ? 1'b0 : ~last_gnt;
  end

  assign idle     = (state_q == IDLE);
  assign req0_rdy = rst_n & idle & req0_vld & ~gnt_id;
  assign req1_rdy = rst_n & idle & req1_vld & gnt_id;
  assign accept   = req0_rdy | req1_rdy;
  assign gnt_mant = gnt_id ? req1_mant : req0_mant;
  assign gnt_amt  = gnt_id ? req1_amt : req0_amt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   state_d = HOLD;
      HOLD:    if (rsp_rdy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  right_shifter u_shifter (
    .din  (op_mant),
    .amt  (op_amt),
    .dout (shift_out)
  );

  assign sticky_mask = (op_amt >= 5'd24) ? 24'hFF_FFFF : ((24'd1 << op_amt) - 24'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_mant    <= '0;
      op_amt     <= '0;
      op_id      <= 1'b0;
      last_gnt   <= 1'b1;
      rsp_id     <= 1'b0;
      rsp_mant   <= '0;
      rsp_sticky <= 1'b0;
    end else begin
      if (accept) begin
        op_mant  <= gnt_mant;
        op_amt   <= clamp_amt(gnt_amt);
        op_id    <= gnt_id;
        last_gnt <= gnt_id;
      end
      if (state_q == SHIFT) begin
        rsp_mant   <= shift_out;
        rsp_sticky <= |(op_mant & sticky_mask);
        rsp_id     <= op_id;
      end
    end
  end

  assign rsp_vld = (state_q == HOLD);
  assign busy    = (state_q != IDLE);

endmodule
